// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the 8-bit accumulator CPU.
// This package holds the opcode and phase encodings, the fixed widths, and the
// helper that classifies ALU-class opcodes.
package cpu_sequencer_pkg;

    localparam int OPW = 3;  // opcode width, also the ALU operation width
    localparam int PHW = 3;  // phase register width (8 phases)

    typedef enum logic [OPW-1:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    typedef enum logic [PHW-1:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    // True for opcodes that read a memory operand and write the accumulator.
    function automatic logic is_aluop(input logic [OPW-1:0] op);
        logic res;
        case (opcode_e'(op))
            OP_ADD, OP_AND, OP_XOR, OP_LDA: res = 1'b1;
            default:                        res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Phase sequencer and control decoder for the 8-bit accumulator CPU.
// Steps an 8-phase instruction cycle and decodes phase, opcode and the ALU zero
// flag into the datapath strobes.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   opcode   in   IR[7:5], stable from phase IDLE onward
//   skz_cmp  in   ALU zero flag, only looked at in phase ALU_OP
//   phase    out  current phase
//   sel      out  1 = PC addresses memory, 0 = IR operand
//   rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr  out  datapath strobes
//   alu_op   out  ALU operation, captured from opcode at the end of IDLE
//   halt     out  sticky halt flag, cleared only by rst
module cpu_sequencer
    import cpu_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           skz_cmp,
    output logic [PHW-1:0] phase,
    output logic           sel,
    output logic           rd,
    output logic           ld_ir,
    output logic           inc_pc,
    output logic           ld_pc,
    output logic           ld_ac,
    output logic           data_e,
    output logic           wr,
    output logic [OPW-1:0] alu_op,
    output logic           halt
);

    phase_e         phase_r;
    phase_e         phase_next_s;
    logic           halt_r;
    logic           halt_next_s;
    logic [OPW-1:0] alu_op_r;
    logic           op_alu_s;
    logic           op_skz_s;
    logic           op_sto_s;
    logic           op_jmp_s;

    assign op_alu_s = is_aluop(opcode);
    assign op_skz_s = (opcode == OP_SKZ);
    assign op_sto_s = (opcode == OP_STO);
    assign op_jmp_s = (opcode == OP_JMP);

    // State registers: phase counter, sticky halt flag and captured ALU operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r  <= PH_INST_ADDR;
            halt_r   <= 1'b0;
            alu_op_r <= 3'd0;
        end else begin
            phase_r <= phase_next_s;
            halt_r  <= halt_next_s;
            if ((phase_r == PH_IDLE) && !halt_r) begin
                alu_op_r <= opcode;
            end else begin
                alu_op_r <= alu_op_r;
            end
        end
    end

    // Next phase and halt: a HLT seen in OP_ADDR parks the sequencer in that
    // phase for good; otherwise the phase simply counts and wraps 7 -> 0.
    always_comb begin
        phase_next_s = phase_r;
        halt_next_s  = halt_r;
        if (halt_r) begin
            phase_next_s = phase_r;
            halt_next_s  = 1'b1;
        end else if ((phase_r == PH_OP_ADDR) && (opcode == OP_HLT)) begin
            phase_next_s = phase_r;
            halt_next_s  = 1'b1;
        end else begin
            phase_next_s = phase_e'(phase_r + 3'd1);
            halt_next_s  = 1'b0;
        end
    end

    // Strobe decode from the registered phase; halt forces every strobe low.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        data_e = 1'b0;
        wr     = 1'b0;
        if (halt_r) begin
            sel = 1'b0;
        end else begin
            case (phase_r)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                end
                PH_OP_FETCH: begin
                    rd = op_alu_s;
                end
                PH_ALU_OP: begin
                    // The zero flag is consulted only here, to skip the next word.
                    rd     = op_alu_s;
                    inc_pc = op_skz_s & skz_cmp;
                    ld_pc  = op_jmp_s;
                    data_e = op_sto_s;
                end
                PH_STORE: begin
                    rd     = op_alu_s;
                    ld_ac  = op_alu_s;
                    ld_pc  = op_jmp_s;
                    data_e = op_sto_s;
                    wr     = op_sto_s;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign phase  = phase_r;
    assign alu_op = alu_op_r;
    assign halt   = halt_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: the driver pushes a hand-derived expected
// vector for every cycle it drives; a monitor on the falling edge pops and compares.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       skz_cmp;
    logic [2:0] phase;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr;
    logic [2:0] alu_op;
    logic       halt;

    typedef struct {
        logic [2:0] ph;
        logic [7:0] strb;   // {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,data_e,wr}
        logic [2:0] alu;
        logic       hlt;
        string      name;
    } exp_t;

    exp_t       sb[$];
    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    logic [2:0] prev_op  = 3'd0;

    cpu_sequencer dut (
        .clk(clk), .rst(rst), .opcode(opcode), .skz_cmp(skz_cmp),
        .phase(phase), .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc),
        .ld_pc(ld_pc), .ld_ac(ld_ac), .data_e(data_e), .wr(wr),
        .alu_op(alu_op), .halt(halt)
    );

    always #5 clk = ~clk;

    // Hand table of strobes per opcode and phase (not halted).
    function automatic logic [7:0] exp_strb(input logic [2:0] op, input logic [2:0] p,
                                            input logic skz);
        logic [7:0] v;
        case (p)
            3'd0: v = 8'h80;
            3'd1: v = 8'hC0;
            3'd2: v = 8'hE0;
            3'd3: v = 8'hE0;
            3'd4: v = 8'h10;
            default: begin
                case (op)
                    3'd2, 3'd3, 3'd4, 3'd5: v = (p == 3'd7) ? 8'h44 : 8'h40;
                    3'd1:                   v = ((p == 3'd6) && skz) ? 8'h10 : 8'h00;
                    3'd6:                   v = (p == 3'd5) ? 8'h00 : ((p == 3'd6) ? 8'h02 : 8'h03);
                    3'd7:                   v = (p == 3'd5) ? 8'h00 : 8'h08;
                    default:                v = 8'h00;
                endcase
            end
        endcase
        return v;
    endfunction

    task automatic step(input logic [2:0] op, input logic skz, input logic r,
                        input logic [2:0] eph, input logic [7:0] estrb,
                        input logic [2:0] ealu, input logic ehlt, input string nm);
        exp_t e;
        opcode  = op;
        skz_cmp = skz;
        rst     = r;
        e.ph = eph; e.strb = estrb; e.alu = ealu; e.hlt = ehlt; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One full instruction; skz_cmp is the opposite of skz6 outside phase 6 so
    // that sampling in the wrong phase would show up.  Optional reset in phase 6.
    task automatic run_instr(input logic [2:0] op, input logic skz6,
                             input logic rst_in_p6, input string nm);
        for (int p = 0; p < 8; p++) begin
            logic [2:0] pp;
            logic       s;
            pp = 3'(p);
            s  = (p == 6) ? skz6 : ~skz6;
            step(op, s, (p == 6) && rst_in_p6, pp, exp_strb(op, pp, skz6),
                 (p >= 4) ? op : prev_op, 1'b0, nm);
            if (rst_in_p6 && (p == 6)) begin
                prev_op = 3'd0;
                return;
            end
        end
        prev_op = op;
    endtask

    // Monitor: compare DUT outputs against the head of the scoreboard.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = sb.pop_front();
            act = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr};
            chk_cnt++;
            if (phase === e.ph) pass_cnt++;
            else $display("FAIL %s phase: got %0d want %0d", e.name, phase, e.ph);
            chk_cnt++;
            if (act === e.strb) pass_cnt++;
            else $display("FAIL %s strobes(ph %0d): got %b want %b", e.name, e.ph, act, e.strb);
            chk_cnt++;
            if (alu_op === e.alu) pass_cnt++;
            else $display("FAIL %s alu_op(ph %0d): got %0d want %0d", e.name, e.ph, alu_op, e.alu);
            chk_cnt++;
            if (halt === e.hlt) pass_cnt++;
            else $display("FAIL %s halt(ph %0d): got %b want %b", e.name, e.ph, halt, e.hlt);
        end
    end

    initial begin
        rst = 1'b1; opcode = 3'd0; skz_cmp = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        // Reset state, then every opcode class
        run_instr(3'd2, 1'b0, 1'b0, "add");
        run_instr(3'd1, 1'b1, 1'b0, "skz_taken");
        run_instr(3'd1, 1'b0, 1'b0, "skz_not_taken");
        run_instr(3'd6, 1'b0, 1'b0, "sto");
        run_instr(3'd7, 1'b1, 1'b0, "jmp");
        run_instr(3'd3, 1'b0, 1'b0, "and");
        run_instr(3'd4, 1'b1, 1'b0, "xor");
        run_instr(3'd5, 1'b0, 1'b0, "lda");
        // Reset in phase 6 of a STO, then a clean instruction from phase 0
        run_instr(3'd6, 1'b0, 1'b1, "sto_rst");
        run_instr(3'd2, 1'b0, 1'b0, "add_after_rst");
        // HLT: phases 0..4, then parked in phase 4 with strobes low
        for (int p = 0; p < 5; p++) begin
            step(3'd0, 1'b1, 1'b0, 3'(p), exp_strb(3'd0, 3'(p), 1'b0),
                 (p >= 4) ? 3'd0 : prev_op, 1'b0, "hlt");
        end
        for (int i = 0; i < 22; i++) begin
            step((i < 11) ? 3'd0 : 3'd2, i[0], (i == 21), 3'd4, 8'h00, 3'd0, 1'b1, "halted");
        end
        prev_op = 3'd0;
        run_instr(3'd7, 1'b0, 1'b0, "jmp_after_halt");
        // Drain, bounded
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            chk_cnt++;
            $display("FAIL drain: got %0d entries left want 0", sb.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
